fp_mul_seq: RTL

Parametrised sequential IEEE-754 floating-point multiplier for the ALU_IEEE754 datapath, next generation of the multiply unit.
- Operand format is set by EXP_W/MAN_W: single precision by default, half or other formats by override.
- Uses a trig/vld handshake with a shift-add mantissa core (one bit per cycle), round-to-nearest-even, full special-case handling and status flags.
- Sits beside the add/sub units under the ALU top, which issues one operation at a time.

---
 rtl/fp_mul_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential IEEE-754 multiplier, shift-add mantissa core, RNE, flush-to-zero
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [EXP_W+MAN_W:0]   data1_in,
  input  logic [EXP_W+MAN_W:0]   data2_in,
  input  logic                   trig,
  output logic [EXP_W+MAN_W:0]   data_out,
  output logic                   vld,
  output logic                   busy,
  output logic                   flag_invalid,
  output logic                   flag_overflow,
  output logic                   flag_underflow,
  output logic                   flag_inexact
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;
  localparam int P  = 2 * M;
  localparam int CW = $clog2(M + 1);
  localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
  localparam logic [1:0] SP_NONE = 2'd0, SP_NAN = 2'd1, SP_INF = 2'd2, SP_ZERO = 2'd3;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic [1:0]       sp_q, sp_d;
  logic [EXP_W+1:0] e_q, e_d;
  logic [M-1:0]     ma_q, ma_d, mb_q, mb_d;
  logic [P-1:0]     acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] f1, f2;
  logic             z1, z2, i1, i2, n1, n2;
  logic [M:0]       sum;
  logic [P-1:0]     norm;
  logic [M-1:0]     mant;
  logic             guard, sticky, inc;
  logic [M:0]       rnd;
  logic [EXP_W+1:0] e_n;
  logic             ovf, unf;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    sp_d    = sp_q;
    e_d     = e_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;

    e1 = data1_in[W-2 -: EXP_W];
    e2 = data2_in[W-2 -: EXP_W];
    f1 = data1_in[MAN_W-1:0];
    f2 = data2_in[MAN_W-1:0];
    z1 = (e1 == '0);
    z2 = (e2 == '0);
    i1 = (&e1) && (f1 == '0);
    i2 = (&e2) && (f2 == '0);
    n1 = (&e1) && (f1 != '0);
    n2 = (&e2) && (f2 != '0);

    // right-shifting accumulator: the high half collects partial sums, low half the retired bits
    sum = {1'b0, acc_q[P-1:M]} + (mb_q[0] ? {1'b0, ma_q} : '0);

    norm   = acc_q[P-1] ? acc_q : (acc_q << 1);
    mant   = norm[P-1 -: M];
    guard  = norm[M-1];
    sticky = |norm[M-2:0];
    inc    = guard & (sticky | mant[0]);
    rnd    = {1'b0, mant} + {{M{1'b0}}, inc};
    e_n    = e_q + {{(EXP_W+1){1'b0}}, acc_q[P-1]} + {{(EXP_W+1){1'b0}}, rnd[M]};
    ovf    = !e_n[EXP_W+1] && (e_n[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}});
    unf    = e_n[EXP_W+1] || (e_n == '0);

    case (state_q)
      IDLE: begin
        if (trig) begin
          sign_d  = data1_in[W-1] ^ data2_in[W-1];
          if (n1 || n2 || (i1 && z2) || (i2 && z1)) sp_d = SP_NAN;
          else if (i1 || i2)                        sp_d = SP_INF;
          else if (z1 || z2)                        sp_d = SP_ZERO;
          else                                      sp_d = SP_NONE;
          e_d     = {2'b00, e1} + {2'b00, e2} - BIAS;
          ma_d    = {1'b1, f1};
          mb_d    = {1'b1, f2};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = {sum, acc_q[M-1:1]};
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(M - 1)) state_d = NORM;
      end
      NORM: begin
        state_d = DONE;
        // specials still run the full multiply so latency never depends on the operands
        case (sp_q)
          SP_NAN: begin
            res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flags_d = 4'b1000;
          end
          SP_INF: begin
            res_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = 4'b0000;
          end
          SP_ZERO: begin
            res_d   = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            flags_d = 4'b0000;
          end
          default: begin
            if (ovf) begin
              res_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              flags_d = 4'b0101;
            end else if (unf) begin
              res_d   = {sign_q, {(EXP_W+MAN_W){1'b0}}};
              flags_d = 4'b0011;
            end else begin
              res_d   = {sign_q, e_n[EXP_W-1:0], rnd[MAN_W-1:0]};
              flags_d = {3'b000, guard | sticky};
            end
          end
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      sp_q    <= SP_NONE;
      e_q     <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      sp_q    <= sp_d;
      e_q     <= e_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign data_out       = res_q;
  assign vld            = (state_q == DONE);
  assign busy           = (state_q == MUL) || (state_q == NORM);
  assign flag_invalid   = flags_q[3];
  assign flag_overflow  = flags_q[2];
  assign flag_underflow = flags_q[1];
  assign flag_inexact   = flags_q[0];

endmodule
